// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: latches a 128-bit state, mixes one column per clock (MSB column first),
// then holds the result until accepted. Defining MIXCOL_INV_EN adds the `inv` port and the inverse transform.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    logic [1:0]     col_q;
    logic [127:0]   data_q;
    logic [127:0]   out_q;
`ifdef MIXCOL_INV_EN
    logic           inv_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Column position counts down from the MSB column as col_q counts up.
    logic [1:0]  col_pos;
    logic [31:0] src_col;
    logic [7:0]  a [4];
    logic [7:0]  fwd_b [4];
    logic [31:0] fwd_col;
    logic [31:0] mix_col_d;

    assign col_pos = ~col_q;
    assign src_col = data_q[{col_pos, 5'b0} +: 32];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fwd
            // Row gi sits at byte offset (3-gi) inside the column word.
            assign a[gi]     = src_col[(3-gi)*8 +: 8];
            assign fwd_b[gi] = xtime(a[gi])
                             ^ (xtime(a[(gi+1)%4]) ^ a[(gi+1)%4])
                             ^ a[(gi+2)%4]
                             ^ a[(gi+3)%4];
            assign fwd_col[(3-gi)*8 +: 8] = fwd_b[gi];
        end
    endgenerate

`ifdef MIXCOL_INV_EN
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  inv_b [4];
    logic [31:0] inv_col;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv
            assign x2[gi] = xtime(a[gi]);
            assign x4[gi] = xtime(x2[gi]);
            assign x8[gi] = xtime(x4[gi]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_inv_row
            // Coefficients 0e, 0b, 0d, 09 built from the doubling chain.
            assign inv_b[gi] = (x8[gi] ^ x4[gi] ^ x2[gi])
                             ^ (x8[(gi+1)%4] ^ x2[(gi+1)%4] ^ a[(gi+1)%4])
                             ^ (x8[(gi+2)%4] ^ x4[(gi+2)%4] ^ a[(gi+2)%4])
                             ^ (x8[(gi+3)%4] ^ a[(gi+3)%4]);
            assign inv_col[(3-gi)*8 +: 8] = inv_b[gi];
        end
    endgenerate

    assign mix_col_d = inv_q ? inv_col : fwd_col;
`else
    assign mix_col_d = fwd_col;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign out_state = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            data_q  <= 128'h0;
            out_q   <= 128'h0;
`ifdef MIXCOL_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_state;
`ifdef MIXCOL_INV_EN
                        inv_q   <= inv;
`endif
                        col_q   <= 2'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    out_q[{col_pos, 5'b0} +: 32] <= mix_col_d;
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            data_q  <= in_state;
`ifdef MIXCOL_INV_EN
                            inv_q   <= inv;
`endif
                            col_q   <= 2'd0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: reset, latency, hold/backpressure, streaming, mid-block reset,
// and (with MIXCOL_INV_EN) the inverse transform.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef MIXCOL_INV_EN
    logic         inv;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] BLK_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] RES_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BLK_B = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] RES_B = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] BLK_C = 128'hc6c6c6c6_01010101_f20a225c_db135345;
    localparam logic [127:0] RES_C = 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef MIXCOL_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        out_ready = 1'b0;
`ifdef MIXCOL_INV_EN
        inv       = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_out_state", out_state, 128'h0);

        // Single block, consumer ready: valid appears four edges after acceptance.
        in_state  = BLK_A;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_state = 128'h0;
        chk("a_busy_ready", {127'h0, in_ready}, 128'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_not_valid", {127'h0, out_valid}, 128'h0);
        end
        step();
        chk("a_valid", {127'h0, out_valid}, 128'h1);
        chk("a_result", out_state, RES_A);
        step();
        chk("a_idle_valid", {127'h0, out_valid}, 128'h0);

        // Backpressure: result must hold and ignore in_valid pulses.
        out_ready = 1'b0;
        in_state  = BLK_B;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("b_valid", {127'h0, out_valid}, 128'h1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = BLK_C;
            chk("b_hold_ready", {127'h0, in_ready}, 128'h0);
            step();
            chk("b_hold_valid", {127'h0, out_valid}, 128'h1);
            chk("b_hold_data", out_state, RES_B);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("b_release", {127'h0, out_valid}, 128'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("b_no_accept", {127'h0, out_valid}, 128'h0);
        end

        // Back-to-back streaming: one result every five cycles, in order.
        begin
            logic [127:0] blks [3];
            logic [127:0] ress [3];
            blks = '{BLK_A, BLK_B, BLK_C};
            ress = '{RES_A, RES_B, RES_C};
            in_state = blks[0];
            in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                if (i < 2) in_state = blks[i+1];
                else       in_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("s_not_valid", {127'h0, out_valid}, 128'h0);
                end
                step();
                chk("s_valid", {127'h0, out_valid}, 128'h1);
                chk("s_result", out_state, ress[i]);
            end
            step();
            chk("s_idle", {127'h0, out_valid}, 128'h0);
        end

        // Reset during BUSY with col=2 discards the block.
        in_state = BLK_B;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_out_state", out_state, 128'h0);
        chk("r_in_ready", {127'h0, in_ready}, 128'h1);
        chk("r_out_valid", {127'h0, out_valid}, 128'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("r_no_pulse", {127'h0, out_valid}, 128'h0);
        end

`ifdef MIXCOL_INV_EN
        in_state = RES_A;
        inv      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        inv      = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("i_valid", {127'h0, out_valid}, 128'h1);
        chk("i_result", out_state, BLK_A);
        step();
        in_state = BLK_A;
        inv      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        inv      = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("f_valid", {127'h0, out_valid}, 128'h1);
        chk("f_result", out_state, RES_A);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
